// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone slave monitor.
// Violation codes are listed in reporting priority, highest first.
package wb_pkg;

    typedef enum logic [2:0] {
        VIOL_NONE          = 3'd0,
        VIOL_ACK_AND_ERR   = 3'd1,
        VIOL_RESP_NO_REQ   = 3'd2,
        VIOL_STB_NO_CYC    = 3'd3,
        VIOL_REQ_CHANGED   = 3'd4,
        VIOL_OVERFLOW      = 3'd5,
        VIOL_ACK_TIMEOUT   = 3'd6,
        VIOL_STALL_TIMEOUT = 3'd7
    } viol_code_e;

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating cycle counter that flags once, on the step that reaches Limit.
module wb_timeout_counter #(
    parameter int Limit = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CountW = $clog2(Limit + 1);
    localparam logic [CountW-1:0] LimitVal = CountW'(Limit);
    localparam logic [CountW-1:0] LastVal  = CountW'(Limit - 1);

    logic [CountW-1:0] count;

    // Once saturated at Limit the count stops moving, so expired cannot re-fire.
    assign expired = run && !clear && (count == LastVal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && (count != LimitVal)) begin
            count <= count + CountW'(1);
        end
    end

endmodule

// File: rtl/wb_slave_monitor.sv
// Passive pipelined-Wishbone protocol monitor: tracks outstanding requests,
// counts completions and aborts, and latches the first protocol violation.
module wb_slave_monitor
    import wb_pkg::*;
#(
    parameter int DataWidth      = 32,
    parameter int AddrWidth      = 30,
    parameter int MaxOutstanding = 4,
    parameter int AckTimeout     = 64,
    parameter int StallTimeout   = 64,
    parameter int CountWidth     = 16
) (
    input  logic                                 clk_i,
    input  logic                                 reset_ni,
    input  logic [DataWidth-1:0]                 wb_data_o,
    input  logic                                 wb_ack_o,
    input  logic                                 wb_stall_o,
    input  logic                                 wb_err_o,
    input  logic [DataWidth-1:0]                 wb_data_i,
    input  logic [AddrWidth-1:0]                 wb_addr_i,
    input  logic [DataWidth/8-1:0]               wb_sel_i,
    input  logic                                 wb_cyc_i,
    input  logic                                 wb_stb_i,
    input  logic                                 wb_we_i,
    output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
    output logic                                 violation_o,
    output logic                                 violation_pulse_o,
    output logic [2:0]                           violation_code_o,
    output logic [CountWidth-1:0]                txn_count_o,
    output logic [7:0]                           abort_count_o
);

    localparam int OutW = $clog2(MaxOutstanding + 1);
    localparam int SumW = OutW + 1;
    localparam logic [SumW-1:0] MaxOut = SumW'(MaxOutstanding);

    logic            accept;
    logic            complete;
    logic            stalled;
    logic            abort;
    logic            req_changed;
    logic            overflow;
    logic            ack_run;
    logic            ack_clear;
    logic            ack_expired;
    logic            stall_expired;
    logic [SumW-1:0] out_sum;
    logic [OutW-1:0] out_next;
    viol_code_e      code;

    logic                   cyc_q;
    logic                   stalled_q;
    logic                   we_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth/8-1:0] sel_q;
    logic [DataWidth-1:0]   data_q;

    // Read data carries no protocol information for this monitor.
    logic unused_read_data;
    assign unused_read_data = ^wb_data_o;

    always_comb begin
        accept   = wb_cyc_i && wb_stb_i && !wb_stall_o;
        complete = wb_ack_o || wb_err_o;
        stalled  = wb_cyc_i && wb_stb_i && wb_stall_o;
        abort    = cyc_q && !wb_cyc_i && (outstanding_o != '0);

        req_changed = stalled_q && wb_cyc_i && wb_stb_i &&
                      ((wb_addr_i != addr_q) || (wb_we_i != we_q) ||
                       (wb_sel_i != sel_q) || (wb_we_i && (wb_data_i != data_q)));

        // A response with nothing outstanding is not subtracted, so the count never underflows.
        out_sum = {1'b0, outstanding_o} + SumW'(accept);
        if (complete && (out_sum != '0)) begin
            out_sum = out_sum - SumW'(1);
        end
        overflow = (out_sum > MaxOut);

        out_next = out_sum[OutW-1:0];
        if (abort) begin
            out_next = '0;
        end else if (overflow) begin
            out_next = MaxOut[OutW-1:0];
        end

        ack_run   = (outstanding_o != '0) && !complete;
        ack_clear = !ack_run || abort;

        code = VIOL_NONE;
        if (wb_ack_o && wb_err_o) begin
            code = VIOL_ACK_AND_ERR;
        end else if (complete && (outstanding_o == '0) && !accept) begin
            code = VIOL_RESP_NO_REQ;
        end else if (wb_stb_i && !wb_cyc_i) begin
            code = VIOL_STB_NO_CYC;
        end else if (req_changed) begin
            code = VIOL_REQ_CHANGED;
        end else if (overflow) begin
            code = VIOL_OVERFLOW;
        end else if (ack_expired) begin
            code = VIOL_ACK_TIMEOUT;
        end else if (stall_expired) begin
            code = VIOL_STALL_TIMEOUT;
        end
    end

    wb_timeout_counter #(
        .Limit (AckTimeout)
    ) u_ack_timeout (
        .clk     (clk_i),
        .rst_n   (reset_ni),
        .run     (ack_run),
        .clear   (ack_clear),
        .expired (ack_expired)
    );

    wb_timeout_counter #(
        .Limit (StallTimeout)
    ) u_stall_timeout (
        .clk     (clk_i),
        .rst_n   (reset_ni),
        .run     (stalled),
        .clear   (!stalled),
        .expired (stall_expired)
    );

    // Request fields are sampled every cycle; they are only compared after a stalled cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            outstanding_o     <= '0;
            violation_o       <= 1'b0;
            violation_pulse_o <= 1'b0;
            violation_code_o  <= 3'd0;
            txn_count_o       <= '0;
            abort_count_o     <= 8'd0;
            cyc_q             <= 1'b0;
            stalled_q         <= 1'b0;
            we_q              <= 1'b0;
            addr_q            <= '0;
            sel_q             <= '0;
            data_q            <= '0;
        end else begin
            outstanding_o     <= out_next;
            violation_pulse_o <= (code != VIOL_NONE);
            cyc_q             <= wb_cyc_i;
            stalled_q         <= stalled;
            we_q              <= wb_we_i;
            addr_q            <= wb_addr_i;
            sel_q             <= wb_sel_i;
            data_q            <= wb_data_i;

            if (!violation_o && (code != VIOL_NONE)) begin
                violation_o      <= 1'b1;
                violation_code_o <= code;
            end

            if (wb_ack_o && !wb_err_o && ((outstanding_o != '0) || accept) &&
                (txn_count_o != '1)) begin
                txn_count_o <= txn_count_o + CountWidth'(1);
            end

            if (abort && (abort_count_o != 8'hFF)) begin
                abort_count_o <= abort_count_o + 8'd1;
            end
        end
    end

endmodule

// File: doc/wb_slave_monitor.md
WB_SLAVE_MONITOR -- requirements
Module: wb_slave_monitor

Interface
REQ-001 SHALL have parameter DataWidth, default 32, data bus width (multiple of 8).
REQ-002 SHALL have parameter AddrWidth, default 30, word address width.
REQ-003 SHALL have parameter MaxOutstanding, default 4, maximum accepted-but-unacknowledged requests (1..255).
REQ-004 SHALL have parameter AckTimeout, default 64, maximum cycles with outstanding>0 and no ack/err.
REQ-005 SHALL have parameter StallTimeout, default 64, maximum consecutive cycles of stb&stall.
REQ-006 SHALL have parameter CountWidth, default 16, width of the completed-transaction counter.
REQ-007 Ports (all wb_* are inputs, observed only): clk_i in 1 clock; reset_ni in 1 async active-low reset; wb_data_o in DataWidth; wb_ack_o in 1; wb_stall_o in 1; wb_err_o in 1; wb_data_i in DataWidth; wb_addr_i in AddrWidth; wb_sel_i in DataWidth/8; wb_cyc_i in 1; wb_stb_i in 1; wb_we_i in 1.
REQ-008 Outputs: outstanding_o out $clog2(MaxOutstanding+1) current outstanding count; violation_o out 1 sticky violation flag; violation_pulse_o out 1 one-cycle flag per violating cycle; violation_code_o out 3 code of first violation; txn_count_o out CountWidth completed transactions; abort_count_o out 8 cycle aborts seen.

Function
REQ-009 Accept = cyc&stb&!stall; complete = ack|err; outstanding_next = outstanding + accept - complete, evaluated same cycle, registered.
REQ-010 Violation codes, checked every cycle, priority highest first: 1 ACK_AND_ERR (ack&err); 2 RESP_NO_REQ (complete while outstanding=0 and cyc low, or outstanding=0 without same-cycle accept); 3 STB_NO_CYC (stb&!cyc); 4 REQ_CHANGED; 5 OVERFLOW (outstanding_next>MaxOutstanding); 6 ACK_TIMEOUT; 7 STALL_TIMEOUT; 0 none.
REQ-011 REQ_CHANGED: when previous cycle had cyc&stb&stall and current has cyc&stb, any change in addr, we, sel, or (if we) data_i SHALL flag.
REQ-012 ACK_TIMEOUT: counter increments while outstanding>0 and !complete, clears on complete or outstanding=0; flag when counter reaches AckTimeout; counter saturates.
REQ-013 STALL_TIMEOUT: counter increments while cyc&stb&stall, clears otherwise; flag at StallTimeout; saturates.
REQ-014 violation_pulse_o SHALL be registered, asserted the cycle after any violating cycle.
REQ-015 violation_o/violation_code_o SHALL latch on first violation and hold until reset; later violations do not overwrite.
REQ-016 Abort: cyc falling (1->0) with outstanding>0 SHALL clear outstanding and both timeout counters, increment abort_count_o (saturating at 255), not a violation.
REQ-017 txn_count_o SHALL increment on each ack (not err) with valid outstanding, saturating at all-ones.
REQ-018 On OVERFLOW, outstanding SHALL saturate at MaxOutstanding; on RESP_NO_REQ it SHALL stay 0 (no underflow).
REQ-019 Accept and complete in the same cycle SHALL leave outstanding unchanged.

Reset
REQ-020 Asynchronous assertion on reset_ni low: all outputs, counters, sampled request registers to 0.
REQ-021 First monitored cycle after reset release SHALL not evaluate REQ_CHANGED.

Structure
REQ-022 Violation code enum (3 bits) SHALL live in shared package wb_pkg.
REQ-023 Timeout counting SHALL use one sub-module, wb_timeout_counter (parameter Limit; inputs run, clear; output expired), instantiated twice.
REQ-024 Block SHALL be bindable beside any wb slave; no combinational path to wb_* signals.

Verification
REQ-025 Two single reads, each acked after 2 cycles -> outstanding 1,0,1,0; txn_count_o=2; violation_o=0.
REQ-026 Five back-to-back accepts, no ack, MaxOutstanding=4 -> code 5, outstanding_o=4, violation_pulse_o one cycle after fifth accept.
REQ-027 ack=err=1 with outstanding=1 and prior RESP_NO_REQ-free history -> code 1 latched; subsequent ack alone leaves code 1.
REQ-028 Stalled write with addr 0x10 changing to 0x14 while stall high -> code 4.
REQ-029 One accept, no response for 64 cycles (AckTimeout=64) -> code 6 on cycle 64; cyc drop with outstanding=3 -> outstanding 0, abort_count_o=1, no new violation.
REQ-030 reset_ni low mid-burst with outstanding=2 -> all outputs 0 immediately, without a clock edge.
